// File: rtl/apb_mfifo_pkg.sv
// Shared definitions for the APB multi-channel FIFO: register offsets and field positions.
package apb_mfifo_pkg;

    typedef enum logic [1:0] {
        REG_DAT  = 2'd0,
        REG_STS  = 2'd1,
        REG_CFG  = 2'd2,
        REG_INTR = 2'd3
    } reg_e;

    localparam int STS_EMPTY    = 0;
    localparam int STS_AE       = 1;
    localparam int STS_AF       = 2;
    localparam int STS_FULL     = 3;
    localparam int STS_CNT      = 8;
    localparam int STS_CLR      = 31;

    localparam int CFG_AF_TH    = 0;
    localparam int CFG_AE_TH    = 8;
    localparam int CFG_DRAIN    = 16;

    localparam int INTR_OVFL    = 0;
    localparam int INTR_UDFL    = 1;
    localparam int INTR_OVFL_EN = 8;
    localparam int INTR_UDFL_EN = 9;

endpackage

// File: rtl/apb_mfifo_if.sv
// APB slave bus bundle for the multi-channel FIFO.
interface apb_mfifo_if #(
    parameter int ADD_W = 8
) ();
    logic [ADD_W-1:0] paddr;
    logic             psel;
    logic             penable;
    logic             pwrite;
    logic [31:0]      pwdata;
    logic             pready;
    logic [31:0]      prdata;
    logic             pslverr;

    modport master (output paddr, psel, penable, pwrite, pwdata,
                    input  pready, prdata, pslverr);
    modport slave  (input  paddr, psel, penable, pwrite, pwdata,
                    output pready, prdata, pslverr);
endinterface

// File: rtl/apb_mfifo_chan.sv
// One FIFO channel: storage, pointers, count/flags, thresholds, sticky interrupts, drain stream.
module apb_mfifo_chan
    import apb_mfifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DAT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_sel,
    input  logic             i_wr,
    input  reg_e             i_reg,
    input  logic [31:0]      i_wdata,
    input  logic             i_rdy,
    output logic [31:0]      o_rdata,
    output logic             o_err,
    output logic             o_vld,
    output logic [DAT_W-1:0] o_dat,
    output logic             o_irq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DAT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [CNT_W-1:0] r_cnt, r_af_th, r_ae_th;
    logic             r_drain, r_ovfl, r_udfl, r_ovfl_en, r_udfl_en;

    logic w_empty, w_full, w_clr, w_spop, w_push_req, w_pop_req, w_push, w_apb_pop;
    logic w_pop, w_ovfl_ev, w_udfl_ev, w_intr_wr, w_cfg_wr, w_unused_wdata;
    logic [DAT_W-1:0] w_head;

    assign w_empty    = (r_cnt == '0);
    assign w_full     = (r_cnt == FULL_CNT);
    assign w_head     = r_mem[r_rptr];
    assign w_clr      = i_sel && i_wr && (i_reg == REG_STS) && i_wdata[STS_CLR];
    assign w_cfg_wr   = i_sel && i_wr && (i_reg == REG_CFG);
    assign w_intr_wr  = i_sel && i_wr && (i_reg == REG_INTR);
    // Clear suppresses the stream pop; a stream pop frees the slot a full-FIFO push needs.
    assign w_spop     = r_drain && !w_empty && i_rdy && !w_clr;
    assign w_push_req = i_sel && i_wr && (i_reg == REG_DAT);
    assign w_pop_req  = i_sel && !i_wr && (i_reg == REG_DAT);
    assign w_push     = w_push_req && (!w_full || w_spop);
    assign w_apb_pop  = w_pop_req && !r_drain && !w_empty;
    assign w_ovfl_ev  = w_push_req && !w_push;
    assign w_udfl_ev  = w_pop_req && !r_drain && w_empty;
    assign w_pop      = w_apb_pop || w_spop;

    assign o_err  = w_ovfl_ev || w_udfl_ev || (w_pop_req && r_drain);
    assign o_vld  = r_drain && !w_empty;
    assign o_dat  = w_head;
    assign o_irq  = (r_ovfl && r_ovfl_en) || (r_udfl && r_udfl_en);
    assign w_unused_wdata = ^i_wdata;

    // Register read view for the addressed register.
    always_comb begin
        o_rdata = 32'h0;
        case (i_reg)
            REG_DAT:  o_rdata[DAT_W-1:0] = w_apb_pop ? w_head : {DAT_W{1'b0}};
            REG_STS: begin
                o_rdata[STS_EMPTY]         = w_empty;
                o_rdata[STS_AE]            = (r_cnt <= r_ae_th);
                o_rdata[STS_AF]            = (r_cnt >= r_af_th);
                o_rdata[STS_FULL]          = w_full;
                o_rdata[STS_CNT +: CNT_W]  = r_cnt;
            end
            REG_CFG: begin
                o_rdata[CFG_AF_TH +: CNT_W] = r_af_th;
                o_rdata[CFG_AE_TH +: CNT_W] = r_ae_th;
                o_rdata[CFG_DRAIN]          = r_drain;
            end
            REG_INTR: begin
                o_rdata[INTR_OVFL]    = r_ovfl;
                o_rdata[INTR_UDFL]    = r_udfl;
                o_rdata[INTR_OVFL_EN] = r_ovfl_en;
                o_rdata[INTR_UDFL_EN] = r_udfl_en;
            end
            default:  o_rdata = 32'h0;
        endcase
    end

    // Data storage; contents are invalidated through the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata[DAT_W-1:0];
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!rst_n || w_clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Configuration and sticky interrupt state; a hardware event beats a same-cycle W1C.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_af_th   <= FULL_CNT;
            r_ae_th   <= '0;
            r_drain   <= 1'b0;
            r_ovfl    <= 1'b0;
            r_udfl    <= 1'b0;
            r_ovfl_en <= 1'b0;
            r_udfl_en <= 1'b0;
        end else begin
            if (w_cfg_wr) begin
                r_af_th <= i_wdata[CFG_AF_TH +: CNT_W];
                r_ae_th <= i_wdata[CFG_AE_TH +: CNT_W];
                r_drain <= i_wdata[CFG_DRAIN];
            end
            if (w_intr_wr) begin
                r_ovfl_en <= i_wdata[INTR_OVFL_EN];
                r_udfl_en <= i_wdata[INTR_UDFL_EN];
            end
            r_ovfl <= w_ovfl_ev || (r_ovfl && !(w_intr_wr && i_wdata[INTR_OVFL]));
            r_udfl <= w_udfl_ev || (r_udfl && !(w_intr_wr && i_wdata[INTR_UDFL]));
        end
    end

endmodule

// File: rtl/apb_mfifo_top.sv
// APB-mapped multi-channel FIFO: address decode, read mux, error and interrupt aggregation.
module apb_mfifo_top
    import apb_mfifo_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DEPTH     = 8,
    parameter int DAT_W     = 8,
    parameter int APB_ADD_W = 8,
    parameter int APB_DAT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    apb_mfifo_if.slave              apb,
    output logic [NUM_CH-1:0]       out_vld,
    input  logic [NUM_CH-1:0]       out_rdy,
    output logic [NUM_CH*DAT_W-1:0] out_dat,
    output logic                    irq
);
    logic                 w_acc, w_ch_ok, w_err, r_irq, w_unused_addr;
    logic [31:0]          w_ch_idx;
    reg_e                 w_reg;
    logic [NUM_CH-1:0]    w_sel, w_ch_err, w_ch_irq;
    logic [APB_DAT_W-1:0] w_ch_rdata [NUM_CH];
    logic [APB_DAT_W-1:0] w_rdata;

    assign w_acc         = apb.psel && apb.penable;
    assign w_ch_idx      = 32'(apb.paddr[APB_ADD_W-1:4]);
    assign w_ch_ok       = (w_ch_idx < 32'(NUM_CH));
    assign w_reg         = reg_e'(apb.paddr[3:2]);
    assign w_unused_addr = ^apb.paddr[1:0];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_sel[c] = w_acc && (w_ch_idx == 32'(c));
        apb_mfifo_chan #(.DEPTH(DEPTH), .DAT_W(DAT_W)) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_sel   (w_sel[c]),
            .i_wr    (apb.pwrite),
            .i_reg   (w_reg),
            .i_wdata (apb.pwdata),
            .i_rdy   (out_rdy[c]),
            .o_rdata (w_ch_rdata[c]),
            .o_err   (w_ch_err[c]),
            .o_vld   (out_vld[c]),
            .o_dat   (out_dat[c*DAT_W +: DAT_W]),
            .o_irq   (w_ch_irq[c])
        );
    end

    // One-hot select makes an AND-OR mux sufficient.
    always_comb begin
        w_rdata = '0;
        w_err   = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_rdata = w_rdata | (w_ch_rdata[c] & {APB_DAT_W{w_sel[c]}});
            w_err   = w_err | (w_ch_err[c] & w_sel[c]);
        end
    end

    assign apb.pready  = 1'b1;
    assign apb.prdata  = (w_acc && !apb.pwrite) ? w_rdata : '0;
    assign apb.pslverr = w_acc && (!w_ch_ok || w_err);

    // Interrupt line is registered so it lags the sticky bits by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |w_ch_irq;
        end
    end

    assign irq = r_irq;

endmodule

// File: tb/tb_apb_mfifo_top.sv
// Self-checking bench: directed scenarios plus random APB traffic against a queue-based model.
module tb_apb_mfifo_top;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 8;
    localparam int DAT_W  = 8;
    localparam int ADD_W  = 8;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NUM_CH-1:0]       out_rdy = '0;
    logic [NUM_CH-1:0]       out_vld;
    logic [NUM_CH*DAT_W-1:0] out_dat;
    logic                    irq;

    apb_mfifo_if #(.ADD_W(ADD_W)) apb ();

    apb_mfifo_top #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DAT_W(DAT_W), .APB_ADD_W(ADD_W), .APB_DAT_W(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .apb     (apb),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_dat (out_dat),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per channel plus register state.
    logic [7:0] mq [NUM_CH][$];
    int         m_af [NUM_CH];
    int         m_ae [NUM_CH];
    bit         m_drain [NUM_CH];
    bit         m_ov [NUM_CH];
    bit         m_ud [NUM_CH];
    bit         m_oen [NUM_CH];
    bit         m_uen [NUM_CH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            mq[c].delete();
            m_af[c] = DEPTH; m_ae[c] = 0; m_drain[c] = 1'b0;
            m_ov[c] = 1'b0; m_ud[c] = 1'b0; m_oen[c] = 1'b0; m_uen[c] = 1'b0;
        end
    endtask

    function automatic logic [31:0] m_sts(input int c);
        logic [31:0] r;
        int n;
        n = mq[c].size();
        r = 32'h0;
        r[0] = (n == 0);
        r[1] = (n <= m_ae[c]);
        r[2] = (n >= m_af[c]);
        r[3] = (n == DEPTH);
        r[11:8] = n[3:0];
        return r;
    endfunction

    function automatic logic m_irq();
        logic v;
        v = 1'b0;
        for (int c = 0; c < NUM_CH; c++) v = v | (m_ov[c] & m_oen[c]) | (m_ud[c] & m_uen[c]);
        return v;
    endfunction

    // One APB transfer; rdy is applied to out_rdy during the access cycle only.
    task automatic acc(input int ch, input int rg, input bit wr, input logic [31:0] wd,
                       input logic [3:0] rdy, output logic [31:0] got);
        logic [31:0] er;
        logic        ee;
        bit          sp [NUM_CH];
        bit          clr, push, apop, ov, ud;
        int          n;
        string       t;
        er = 32'h0; ee = 1'b0; push = 1'b0; apop = 1'b0; ov = 1'b0; ud = 1'b0;
        t = $sformatf("ch%0d_r%0d_%s", ch, rg, wr ? "wr" : "rd");
        @(negedge clk);
        apb.paddr = 8'(ch * 16 + rg * 4); apb.psel = 1'b1; apb.penable = 1'b0;
        apb.pwrite = wr; apb.pwdata = wd; out_rdy = 4'b0000;
        @(negedge clk);
        apb.penable = 1'b1; out_rdy = rdy;
        #1;
        chk({t, "_irq"}, {31'b0, irq}, {31'b0, m_irq()});
        for (int k = 0; k < NUM_CH; k++) begin
            chk($sformatf("%s_vld%0d", t, k), {31'b0, out_vld[k]},
                {31'b0, (m_drain[k] && mq[k].size() > 0)});
            if (m_drain[k] && mq[k].size() > 0)
                chk($sformatf("%s_dat%0d", t, k), {24'b0, out_dat[k*8 +: 8]}, {24'b0, mq[k][0]});
        end
        clr = (ch < NUM_CH) && wr && (rg == 1) && wd[31];
        for (int k = 0; k < NUM_CH; k++)
            sp[k] = m_drain[k] && rdy[k] && (mq[k].size() > 0) && !(clr && k == ch);
        if (ch >= NUM_CH) begin
            ee = 1'b1;
        end else begin
            n = mq[ch].size();
            case (rg)
                0: begin
                    if (wr) begin
                        if (n < DEPTH || sp[ch]) push = 1'b1;
                        else begin ee = 1'b1; ov = 1'b1; end
                    end else if (m_drain[ch]) ee = 1'b1;
                    else if (n == 0) begin ee = 1'b1; ud = 1'b1; end
                    else begin er = {24'b0, mq[ch][0]}; apop = 1'b1; end
                end
                1: if (!wr) er = m_sts(ch);
                2: if (!wr) er = {15'b0, m_drain[ch], 4'b0, m_ae[ch][3:0], 4'b0, m_af[ch][3:0]};
                3: if (!wr) er = {22'b0, m_uen[ch], m_oen[ch], 6'b0, m_ud[ch], m_ov[ch]};
                default: ;
            endcase
        end
        got = apb.prdata;
        chk({t, "_prdata"}, got, er);
        chk({t, "_pslverr"}, {31'b0, apb.pslverr}, {31'b0, ee});
        for (int k = 0; k < NUM_CH; k++) if (sp[k]) void'(mq[k].pop_front());
        if (apop) void'(mq[ch].pop_front());
        if (push) mq[ch].push_back(wd[7:0]);
        if (ch < NUM_CH && wr) begin
            if (clr) mq[ch].delete();
            if (rg == 2) begin
                m_af[ch] = int'(wd[3:0]); m_ae[ch] = int'(wd[11:8]); m_drain[ch] = wd[16];
            end
            if (rg == 3) begin
                if (wd[0]) m_ov[ch] = 1'b0;
                if (wd[1]) m_ud[ch] = 1'b0;
                m_oen[ch] = wd[8]; m_uen[ch] = wd[9];
            end
        end
        if (ov) m_ov[ch] = 1'b1;
        if (ud) m_ud[ch] = 1'b1;
        @(posedge clk);
        #1;
        apb.psel = 1'b0; apb.penable = 1'b0; out_rdy = 4'b0000;
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] wd;
        int          r, ch;
        apb.paddr = '0; apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.pwdata = '0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_prdata", apb.prdata, 32'h0);
        chk("rst_pslverr", {31'b0, apb.pslverr}, 32'h0);
        chk("rst_pready", {31'b0, apb.pready}, 32'h1);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_out_vld", {28'b0, out_vld}, 32'h0);
        rst_n = 1'b1;

        acc(0, 1, 1'b0, 32'h0, 4'b0, got);
        chk("ch0_sts_reset", got, 32'h0000_0003);

        // ch1: fill, overflow with interrupt enabled
        acc(1, 3, 1'b1, 32'h0000_0100, 4'b0, got);
        for (int i = 0; i < 8; i++) acc(1, 0, 1'b1, 32'hA0 + 32'(i), 4'b0, got);
        acc(1, 1, 1'b0, 32'h0, 4'b0, got);
        chk("ch1_sts_full", got, 32'h0000_080C);
        acc(1, 0, 1'b1, 32'hFF, 4'b0, got);
        @(posedge clk); #1;
        chk("ch1_irq_ovfl", {31'b0, irq}, 32'h1);
        acc(1, 3, 1'b0, 32'h0, 4'b0, got);
        chk("ch1_intr_ovfl", got, 32'h0000_0101);

        // ch1: drain by APB, underflow, clear stickies
        for (int i = 0; i < 8; i++) begin
            acc(1, 0, 1'b0, 32'h0, 4'b0, got);
            chk($sformatf("ch1_pop%0d", i), got, 32'hA0 + 32'(i));
        end
        acc(1, 0, 1'b0, 32'h0, 4'b0, got);
        acc(1, 3, 1'b1, 32'h0000_0003, 4'b0, got);
        acc(1, 3, 1'b0, 32'h0, 4'b0, got);
        chk("ch1_intr_w1c", got, 32'h0);

        // ch0: leave two words to prove isolation later
        acc(0, 0, 1'b1, 32'h55, 4'b0, got);
        acc(0, 0, 1'b1, 32'h66, 4'b0, got);

        // ch2: hardware drain stream
        acc(2, 2, 1'b1, 32'h0001_0008, 4'b0, got);
        acc(2, 0, 1'b1, 32'h11, 4'b0, got);
        acc(2, 0, 1'b1, 32'h22, 4'b0, got);
        acc(2, 0, 1'b1, 32'h33, 4'b0, got);
        @(negedge clk);
        chk("ch2_vld", {31'b0, out_vld[2]}, 32'h1);
        chk("ch2_head", {24'b0, out_dat[23:16]}, 32'h11);
        acc(2, 0, 1'b1, 32'h44, 4'b0100, got);
        acc(2, 1, 1'b0, 32'h0, 4'b0, got);
        chk("ch2_cnt_concurrent", {28'b0, got[11:8]}, 32'd3);
        acc(2, 0, 1'b0, 32'h0, 4'b0, got);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("ch2_stream_vld%0d", i), {31'b0, out_vld[2]}, 32'h1);
            chk($sformatf("ch2_stream_dat%0d", i), {24'b0, out_dat[23:16]}, 32'h22 + 32'(i) * 32'h11);
            out_rdy = 4'b0100;
            @(posedge clk); #1;
            out_rdy = 4'b0000;
            void'(mq[2].pop_front());
        end
        @(negedge clk);
        chk("ch2_stream_done", {31'b0, out_vld[2]}, 32'h0);
        acc(2, 2, 1'b1, 32'h0000_0008, 4'b0, got);

        // ch3: clear beats a same-cycle stream pop
        acc(3, 2, 1'b1, 32'h0001_0008, 4'b0, got);
        for (int i = 0; i < 5; i++) acc(3, 0, 1'b1, 32'hC0 + 32'(i), 4'b0, got);
        acc(3, 1, 1'b1, 32'h8000_0000, 4'b1000, got);
        acc(3, 1, 1'b0, 32'h0, 4'b0, got);
        chk("ch3_sts_clr", got, 32'h0000_0003);
        acc(0, 1, 1'b0, 32'h0, 4'b0, got);
        chk("ch0_sts_kept", got, 32'h0000_0200);
        acc(3, 2, 1'b1, 32'h0000_0008, 4'b0, got);

        // out-of-range channels
        acc(4, 1, 1'b0, 32'h0, 4'b0, got);
        chk("bad_ch_prdata", got, 32'h0);
        acc(15, 0, 1'b1, 32'h77, 4'b0, got);

        // random traffic
        for (int it = 0; it < 400; it++) begin
            r  = $urandom_range(0, 9);
            ch = $urandom_range(0, NUM_CH - 1);
            wd = $urandom;
            case (r)
                0, 1, 2, 3: acc(ch, 0, 1'b1, wd, 4'($urandom_range(0, 15)), got);
                4, 5:       acc(ch, 0, 1'b0, wd, 4'($urandom_range(0, 15)), got);
                6: begin
                    wd[31] = ($urandom_range(0, 3) == 0);
                    acc(ch, 1, 1'($urandom_range(0, 1)), wd, 4'($urandom_range(0, 15)), got);
                end
                7:          acc(ch, 2, 1'($urandom_range(0, 1)), wd, 4'($urandom_range(0, 15)), got);
                8:          acc(ch, 3, 1'($urandom_range(0, 1)), wd, 4'($urandom_range(0, 15)), got);
                default:    acc($urandom_range(NUM_CH, 15), $urandom_range(0, 3),
                                1'($urandom_range(0, 1)), wd, 4'b0, got);
            endcase
        end

        // reset with every channel full
        for (int c = 0; c < NUM_CH; c++) begin
            acc(c, 2, 1'b1, 32'h0001_0008, 4'b0, got);
            acc(c, 1, 1'b1, 32'h8000_0000, 4'b0, got);
            for (int i = 0; i < DEPTH; i++) acc(c, 0, 1'b1, $urandom, 4'b0, got);
        end
        @(negedge clk);
        chk("pre_rst_vld", {28'b0, out_vld}, 32'hF);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_vld", {28'b0, out_vld}, 32'h0);
        chk("mid_rst_irq", {31'b0, irq}, 32'h0);
        rst_n = 1'b1;
        m_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            acc(c, 1, 1'b0, 32'h0, 4'b0, got);
            chk($sformatf("post_rst_sts%0d", c), got, 32'h0000_0003);
            acc(c, 2, 1'b0, 32'h0, 4'b0, got);
            chk($sformatf("post_rst_cfg%0d", c), got, 32'h0000_0008);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
